disp_req_arbiter: RTL
=====================

# disp_req_arbiter

Shares the single 4-digit I2C seven-segment display path (hex encoder plus serial driver) between up to N_REQ independent requesters. Each requester posts a 16-bit hex word. The block grants one request at a time, latches its data, issues one strobe to the driver, and tracks the driver's busy/ack-error handshake to completion. It then enforces a minimum refresh gap before the next transaction. It sits between the application logic (counters, status sources) and the display top level, and replaces the free-running always-start sequencing.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8.
- GAP_CYCLES, 4000: minimum idle cycles between the end of one transaction and the next strobe, ≥1.
- BUSY_TIMEOUT, 16: cycles to wait after the strobe for disp_busy_i to rise, ≥2.

Ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- sync_reset_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  N_REQ  request pending, one bit per requester; level, held until accepted.
- req_data_i  in  N_REQ×16  hex word per requester; digit 0 = bits [3:0].
- req_ready_o  out  N_REQ  one-cycle accept pulse to the granted requester.
- done_o  out  N_REQ  one-cycle completion pulse to the owner of the finished transaction.
- err_o  out  1  one-cycle pulse coincident with done_o when the transaction failed.
- disp_data_o  out  16  hex word to the display encoder; holds the last accepted word.
- disp_strobe_o  out  1  one-cycle start pulse to the driver.
- disp_busy_i  in  1  driver busy.
- disp_ack_error_i  in  1  driver ack-error flag, sampled while busy.
- grant_id_o  out  $clog2(N_REQ)  index of the current or last owner.
- active_o  out  1  high from accept through done.

## Operation
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if any req_valid_i bit is set, select a winner, pulse req_ready_o[winner], latch req_data_i[winner] into disp_data_o and the winner into grant_id_o, clear the error flag, then go to LOAD. If no request is pending, stay in IDLE.
- LOAD: disp_strobe_o=1 for exactly this cycle, then go to WAIT_BUSY.
- WAIT_BUSY: if disp_busy_i=1, go to WAIT_DONE. If BUSY_TIMEOUT cycles pass without busy rising, set the error flag, pulse done_o and err_o, then go to GAP.
- WAIT_DONE: OR disp_ack_error_i into the error flag each cycle. When disp_busy_i=0, pulse done_o[grant_id_o], pulse err_o if the flag is set, then go to GAP.
- GAP: count GAP_CYCLES cycles, then go to IDLE. Requests are ignored during GAP.
- Arbitration, default mode: round-robin. Search starts at (last grant + 1) mod N_REQ. After reset the last grant is N_REQ-1, so requester 0 wins first.
- A requester whose valid bit drops before it is granted is simply not granted. No data is lost from other requesters.
- Counters: one shared counter sized to max(GAP_CYCLES, BUSY_TIMEOUT). It is cleared on every state entry and saturates; it never wraps.

## Timing
- Reset values: req_ready_o=0, done_o=0, err_o=0, disp_strobe_o=0, disp_data_o=16'h0000, grant_id_o=N_REQ-1, active_o=0. The FSM resets to IDLE and the counter to 0.
- Accept cycle T: req_ready_o and the latch happen at T. disp_strobe_o is at T+1. The earliest busy sample is at T+2.
- disp_data_o is stable from T+1 until the next accept. It never changes while active_o=1.
- done_o is asserted in the first cycle that disp_busy_i=0 is sampled in WAIT_DONE. The next accept is no earlier than done + GAP_CYCLES + 1.
- If a request is valid in the same cycle the FSM enters IDLE, it is accepted on that IDLE cycle; there is no extra bubble.
- Reset mid-transaction: all state clears on the next edge and no done_o is issued. The driver may still be busy. The next transaction waits through IDLE → LOAD normally, and the driver is responsible for ignoring a strobe while busy.

## Configuration
- DISP_ARB_FIXED_PRIO_EN defined: fixed priority; the lowest index always wins. The last-grant pointer is still updated for grant_id_o but is not used for selection.
- Not defined: round-robin, as described above.

## Test plan
- Single request: reset, then req_valid_i=4'b0001 with data 16'h2025. Expect req_ready_o[0] at T and strobe at T+1 with disp_data_o=16'h2025. Hold busy for 10 cycles; expect done_o[0] and err_o=0.
- Round-robin: all four requesters valid with data 16'h1111..16'h4444 and GAP_CYCLES=8. Expect grants in order 0,1,2,3,0. With DISP_ARB_FIXED_PRIO_EN defined, expect grants 0,0,0.
- Busy timeout: disp_busy_i tied to 0 with BUSY_TIMEOUT=16. Expect done_o[0] and err_o exactly 16 cycles after the strobe, then GAP.
- Ack error: pulse disp_ack_error_i for 1 cycle mid-busy. Expect err_o=1 with done_o when busy falls.
- Gap enforcement: a request is held valid through GAP. Expect the next req_ready_o exactly GAP_CYCLES+1 cycles after done_o, and disp_data_o unchanged during GAP.
- Reset mid-WAIT_DONE: assert sync_reset_i for one cycle. Expect all outputs at reset values on the next cycle, no done_o, and requester 0 granted first afterward.

Source files
------------

// File: rtl/disp_req_arbiter.sv
// disp_req_arbiter: shares the single seven-segment display path (hex encoder
// plus serial I2C driver) between N_REQ requesters. One request is granted at a
// time, its word is latched, the driver is strobed once, and the driver's
// busy/ack-error handshake is tracked to completion. A minimum refresh gap is
// then enforced before the next grant.
//
// Build option: define DISP_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins). Without it, arbitration is round-robin starting after the last grant.
module disp_req_arbiter #(
    parameter int N_REQ        = 4,
    parameter int GAP_CYCLES   = 4000,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                     clk_i,
    input  logic                     sync_reset_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*16-1:0]      req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic [N_REQ-1:0]         done_o,
    output logic                     err_o,
    output logic [15:0]              disp_data_o,
    output logic                     disp_strobe_o,
    input  logic                     disp_busy_i,
    input  logic                     disp_ack_error_i,
    output logic [$clog2(N_REQ)-1:0] grant_id_o,
    output logic                     active_o
);

    localparam int ID_W    = $clog2(N_REQ);
    localparam int CNT_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ID_W-1:0]   grant_q;
    logic [15:0]       data_q;
    logic              err_flag_q;

    logic              found;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   scan_idx;
    logic              accept;
    logic              finish;
    logic              finish_err;

    // Pick the winning requester among the currently valid ones.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
`ifdef DISP_ARB_FIXED_PRIO_EN
        // Scan from the top so the lowest valid index is the last one written.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
`else
        // Start one past the last owner and take the first valid requester.
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = ID_W'((int'(grant_q) + 1 + i) % N_REQ);
            if (!found && req_valid_i[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
`endif
    end

    // Next-state logic and transaction events of the sequencing FSM.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        finish     = 1'b0;
        finish_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (disp_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q >= BUSY_LAST) begin
                    // Driver never acknowledged the strobe: fail the transaction.
                    finish     = 1'b1;
                    finish_err = 1'b1;
                    state_d    = GAP;
                end
            end
            WAIT_DONE: begin
                if (!disp_busy_i) begin
                    finish     = 1'b1;
                    finish_err = err_flag_q;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shared counter, owner, latched word and error flag registers.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (sync_reset_i) begin
            // NOTE: the display word is a plain register, not a memory, and
            // must read 0 out of reset, so it is reset with the rest.
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= LAST_ID;
            data_q     <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q <= state_d;

            // Counter restarts on every state change and saturates otherwise.
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (accept) begin
                grant_q    <= winner;
                data_q     <= req_data_i[winner*16 +: 16];
                err_flag_q <= 1'b0;
            end else if (state_q == WAIT_DONE && disp_busy_i && disp_ack_error_i) begin
                err_flag_q <= 1'b1;
            end else if (state_q == WAIT_BUSY && finish) begin
                err_flag_q <= 1'b1;
            end
        end
    end

    // Pulse outputs; all held low while reset is asserted.
    always_comb begin
        req_ready_o   = '0;
        done_o        = '0;
        err_o         = 1'b0;
        disp_strobe_o = 1'b0;
        active_o      = 1'b0;
        if (!sync_reset_i) begin
            if (accept) begin
                req_ready_o[winner] = 1'b1;
            end
            if (finish) begin
                done_o[grant_q] = 1'b1;
                err_o           = finish_err;
            end
            disp_strobe_o = (state_q == LOAD);
            active_o      = accept || (state_q inside {LOAD, WAIT_BUSY, WAIT_DONE});
        end
    end

    assign disp_data_o = data_q;
    assign grant_id_o  = grant_q;

endmodule
